// File: rtl/usb_pkg.sv
// Shared USB transmit-path definitions.
//   bs_state_t    : bit stuffer FSM states
//   USB_STUFF_LEN : run of 1s after which USB inserts a 0
package usb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    STUFF
  } bs_state_t;

  localparam int unsigned USB_STUFF_LEN = 6;

endpackage

// File: rtl/bit_stuff_if.sv
// Serial bitstream link around the bit stuffer.
//   master : upstream side (drives inb/recving/pause_in, sees outb/sending/pause_out)
//   slave  : bit stuffer side
// With BIT_STUFF_STATS_EN defined, the link also carries the per-packet stuff_cnt.
interface bit_stuff_if;

  logic inb;
  logic recving;
  logic pause_in;
  logic outb;
  logic sending;
  logic pause_out;
`ifdef BIT_STUFF_STATS_EN
  logic [15:0] stuff_cnt;

  modport master (
    output inb, recving, pause_in,
    input  outb, sending, pause_out, stuff_cnt
  );

  modport slave (
    input  inb, recving, pause_in,
    output outb, sending, pause_out, stuff_cnt
  );
`else
  modport master (
    output inb, recving, pause_in,
    input  outb, sending, pause_out
  );

  modport slave (
    input  inb, recving, pause_in,
    output outb, sending, pause_out
  );
`endif

endinterface

// File: rtl/counter.sv
// Generic up/down counter with synchronous clear.
//   clk, rst_L : clock, asynchronous active-low reset
//   inc        : count enable
//   clr        : synchronous clear, overrides inc
//   up         : count direction (1 = up)
//   cnt        : current count
module counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_L,
  input  logic             inc,
  input  logic             clr,
  input  logic             up,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= up ? cnt + 1'b1 : cnt - 1'b1;
    end
  end

endmodule

// File: rtl/bit_stuff.sv
// USB transmit bit stuffer: passes the serial stream through with zero latency and
// inserts a 0 after every STUFF_LEN consecutive 1s, stalling upstream via pause_out
// for the cycle the inserted 0 is driven.
//   clk, rst_L : clock, asynchronous active-low reset
//   bus        : bit_stuff_if.slave (inb, recving, pause_in in; outb, sending, pause_out out)
// Optional: define BIT_STUFF_STATS_EN to add bus.stuff_cnt, the saturating count of
// stuff bits inserted in the current/most recent packet.
// STUFF_LEN legal range is 2..15.
module bit_stuff
  import usb_pkg::*;
#(
  parameter int unsigned STUFF_LEN = USB_STUFF_LEN
) (
  input logic        clk,
  input logic        rst_L,
  bit_stuff_if.slave bus
);

  localparam logic [3:0] LastOne = 4'(STUFF_LEN - 1);

  bs_state_t  state_q, state_d;
  logic [3:0] ones_cnt;
  logic       in_stuff;
  logic       accept;
  logic       stuff_entry;
  logic       pass_to_idle;
  logic       stuff_exit;
  logic       inc_cnt;
  logic       clr_cnt;

  assign in_stuff     = (state_q == STUFF);
  assign accept       = bus.recving & ~bus.pause_in & ~in_stuff;
  assign stuff_entry  = accept & bus.inb & (ones_cnt == LastOne);
  assign pass_to_idle = (state_q == PASS) & ~bus.recving;
  assign stuff_exit   = in_stuff & ~bus.pause_in;

  // Clear wins over increment inside the counter, so the STUFF_LEN-th 1 leaves it at 0;
  // the inserted 0 thereby restarts the run.
  assign inc_cnt = accept & bus.inb;
  assign clr_cnt = (accept & ~bus.inb) | stuff_entry | pass_to_idle;

  counter #(
    .WIDTH (4)
  ) u_run_cnt (
    .clk   (clk),
    .rst_L (rst_L),
    .inc   (inc_cnt),
    .clr   (clr_cnt),
    .up    (1'b1),
    .cnt   (ones_cnt)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, PASS: begin
        if (stuff_entry) begin
          state_d = STUFF;
        end else if (accept) begin
          state_d = PASS;
        end else if (pass_to_idle) begin
          state_d = IDLE;
        end
      end
      STUFF: begin
        if (!bus.pause_in) begin
          state_d = bus.recving ? PASS : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Reset forces IDLE, so these reduce to pass-through while rst_L is low.
  always_comb begin
    bus.outb      = in_stuff ? 1'b0 : bus.inb;
    bus.sending   = in_stuff | bus.recving;
    bus.pause_out = in_stuff | bus.pause_in;
  end

`ifdef BIT_STUFF_STATS_EN
  logic [15:0] stuff_cnt_q;

  // Cleared at packet start so the value survives past packet end for readout.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      stuff_cnt_q <= '0;
    end else if ((state_q == IDLE) && (state_d == PASS)) begin
      stuff_cnt_q <= '0;
    end else if (stuff_exit && (stuff_cnt_q != 16'hFFFF)) begin
      stuff_cnt_q <= stuff_cnt_q + 16'd1;
    end
  end

  assign bus.stuff_cnt = stuff_cnt_q;
`endif

endmodule

// File: tb/tb_bit_stuff.sv
// Directed bench for bit_stuff: each test pushes input rows and the hand-computed
// stream of transferred output bits; a negedge monitor pops and compares whenever
// the DUT transfers a bit (sending high, no downstream stall).
module tb_bit_stuff;
  import usb_pkg::*;

  logic clk = 1'b0;
  logic rst_L = 1'b0;

  bit_stuff_if bus ();

  bit_stuff #(
    .STUFF_LEN (USB_STUFF_LEN)
  ) dut (
    .clk   (clk),
    .rst_L (rst_L),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0] exp_q[$];  // {outb, pause_out}
  logic [3:0] rows[$];   // {chk_stuff_hold, pause_in, recving, inb}
  logic [1:0] mon_e;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic exp_bits(input int n, input logic b, input logic p);
    for (int i = 0; i < n; i++) exp_q.push_back({b, p});
  endtask

  task automatic row(input int n, input logic b, input logic rv, input logic ps,
                     input logic chk);
    for (int i = 0; i < n; i++) rows.push_back({chk, ps, rv, b});
  endtask

  // Each row holds for one clock cycle; rows flagged chk must show the held stuff 0.
  task automatic run_rows();
    logic [3:0] r;
    while (rows.size() > 0) begin
      r = rows.pop_front();
      @(posedge clk);
      #1;
      bus.inb      = r[0];
      bus.recving  = r[1];
      bus.pause_in = r[2];
      if (r[3]) begin
        @(negedge clk);
        check("stuff_hold", 16'({bus.outb, bus.sending, bus.pause_out}), 16'h3);
      end
    end
  endtask

  task automatic end_test(input string name);
    row(2, 1'b0, 1'b0, 1'b0, 1'b0);
    run_rows();
    @(negedge clk);
    check({"leftover_", name}, 16'(exp_q.size()), 16'h0);
  endtask

  task automatic check_stats(input string name, input logic [15:0] req);
`ifdef BIT_STUFF_STATS_EN
    check({"stuff_cnt_", name}, bus.stuff_cnt, req);
`else
    if (req === 16'hxxxx) $display("unused %s", name);
`endif
  endtask

  always @(negedge clk) begin
    if (rst_L && bus.sending === 1'b1 && bus.pause_in === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: got outb=%b pause_out=%b, expected no transfer (t=%0t)",
                 bus.outb, bus.pause_out, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_bit", 16'({bus.outb, bus.pause_out}), 16'(mon_e));
      end
    end
  end

  initial begin
    bus.inb      = 1'b1;
    bus.recving  = 1'b1;
    bus.pause_in = 1'b1;
    #2;
    check("reset_passthru_hi", 16'({bus.outb, bus.sending, bus.pause_out}), 16'h7);
    bus.inb      = 1'b0;
    bus.recving  = 1'b0;
    bus.pause_in = 1'b0;
    #1;
    check("reset_passthru_lo", 16'({bus.outb, bus.sending, bus.pause_out}), 16'h0);
    check_stats("reset", 16'h0);
    @(negedge clk);
    rst_L = 1'b1;

    // 8 consecutive 1s
    row(9, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_bits(6, 1'b1, 1'b0); exp_bits(1, 1'b0, 1'b1); exp_bits(2, 1'b1, 1'b0);
    end_test("ones8");

    // 0x00 then 0xFF, LSB first
    row(8, 1'b0, 1'b1, 1'b0, 1'b0);
    row(9, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_bits(8, 1'b0, 1'b0);
    exp_bits(6, 1'b1, 1'b0); exp_bits(1, 1'b0, 1'b1); exp_bits(2, 1'b1, 1'b0);
    end_test("byte00ff");
    check_stats("byte00ff", 16'h1);

    // 11111 0 111111: 0 resets the run, stuff after the final bit
    row(5, 1'b1, 1'b1, 1'b0, 1'b0);
    row(1, 1'b0, 1'b1, 1'b0, 1'b0);
    row(6, 1'b1, 1'b1, 1'b0, 1'b0);
    row(1, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_bits(5, 1'b1, 1'b0); exp_bits(1, 1'b0, 1'b0);
    exp_bits(6, 1'b1, 1'b0); exp_bits(1, 1'b0, 1'b1);
    end_test("run5_0_run6");

    // Packet ending on 6th 1, then two short packets: no count carry-over
    row(6, 1'b1, 1'b1, 1'b0, 1'b0);
    row(2, 1'b0, 1'b0, 1'b0, 1'b0);
    row(3, 1'b1, 1'b1, 1'b0, 1'b0);
    row(1, 1'b0, 1'b0, 1'b0, 1'b0);
    row(4, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_bits(6, 1'b1, 1'b0); exp_bits(1, 1'b0, 1'b1); exp_bits(7, 1'b1, 1'b0);
    end_test("pkt_boundary");
    check_stats("pkt_boundary", 16'h0);

    // Downstream stall for 3 cycles while the stuff 0 is held
    row(6, 1'b1, 1'b1, 1'b0, 1'b0);
    row(3, 1'b1, 1'b1, 1'b1, 1'b1);
    row(1, 1'b1, 1'b1, 1'b0, 1'b1);
    row(2, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_bits(6, 1'b1, 1'b0); exp_bits(1, 1'b0, 1'b1); exp_bits(2, 1'b1, 1'b0);
    end_test("stall_in_stuff");
    check_stats("stall_in_stuff", 16'h1);

    // Stall in PASS freezes the run count
    row(3, 1'b1, 1'b1, 1'b0, 1'b0);
    row(2, 1'b1, 1'b1, 1'b1, 1'b0);
    row(3, 1'b1, 1'b1, 1'b0, 1'b0);
    row(1, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_bits(6, 1'b1, 1'b0); exp_bits(1, 1'b0, 1'b1);
    end_test("stall_in_pass");

    // Reset while in STUFF aborts the insertion
    row(6, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_bits(6, 1'b1, 1'b0);
    run_rows();
    @(posedge clk);
    #1;
    bus.inb     = 1'b0;
    bus.recving = 1'b0;
    #1;
    check("stuff_before_rst", 16'({bus.outb, bus.sending, bus.pause_out}), 16'h3);
    rst_L = 1'b0;
    #1;
    check("rst_mid_stuff", 16'({bus.outb, bus.sending, bus.pause_out}), 16'h0);
    check_stats("rst_mid_stuff", 16'h0);
    @(negedge clk);
    #1;
    rst_L = 1'b1;
    row(6, 1'b1, 1'b1, 1'b0, 1'b0);
    row(1, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_bits(6, 1'b1, 1'b0); exp_bits(1, 1'b0, 1'b1);
    end_test("after_rst");
    check_stats("after_rst", 16'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
